xor_bitwise: RTL and testbench

//   Parameterised bitwise XOR unit with a combinational result and a registered copy.
//   f = a ^ b is available in the same cycle, with no clock dependency.
//   A one-stage registered copy also carries valid, zero, parity and popcount flags
//   for downstream datapath consumers (compare/difference logic, checksum paths).
//

---
 rtl/xor_bitwise.sv | 77 +++++++
 tb/tb_xor_bitwise.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/xor_bitwise.sv
// xor_bitwise: bitwise XOR of two operands. The result is available
// combinationally on f, and a one-stage registered copy carries valid,
// zero, parity and popcount (Hamming distance) flags for downstream
// compare, difference and checksum logic.
module xor_bitwise #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] f_q,
    output logic             out_valid,
    output logic             zero_q,
    output logic             parity_q,
    output logic [CNT_W-1:0] ones_q
);

    logic [WIDTH-1:0] w_f;
    logic [CNT_W-1:0] w_ones;
    logic             w_zero;
    logic             w_parity;

    logic [WIDTH-1:0] r_f;
    logic             r_valid;
    logic             r_zero;
    logic             r_parity;
    logic [CNT_W-1:0] r_ones;

    // The XOR path has no clock, reset or valid dependency. X/Z on an
    // input propagates through the native operator, with no masking.
    assign w_f = a ^ b;

    // Flags derived from the live XOR result. The popcount is accumulated
    // at CNT_W bits, which can hold WIDTH, so it never wraps.
    always_comb begin
        w_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ones = w_ones + CNT_W'(w_f[i]);
        end
        w_zero   = (w_f == '0);
        w_parity = ^w_f;
    end

    // Output stage. A valid input overwrites the result and the flags.
    // An idle cycle drops out_valid but keeps the last result visible.
    // The asynchronous reset clears the stage immediately, so a capture
    // in the same cycle as reset is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f      <= '0;
            r_valid  <= 1'b0;
            r_zero   <= 1'b0;
            r_parity <= 1'b0;
            r_ones   <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_f      <= w_f;
                r_zero   <= w_zero;
                r_parity <= w_parity;
                r_ones   <= w_ones;
            end
        end
    end

    assign f         = w_f;
    assign f_q       = r_f;
    assign out_valid = r_valid;
    assign zero_q    = r_zero;
    assign parity_q  = r_parity;
    assign ones_q    = r_ones;

endmodule

// File: tb/tb_xor_bitwise.sv
// Self-checking bench for xor_bitwise: directed boundary cases followed by
// random traffic, compared against a behavioural model of the output stage.
module tb_xor_bitwise;

    localparam int WIDTH = 16;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] f_q;
    logic             out_valid;
    logic             zero_q;
    logic             parity_q;
    logic [CNT_W-1:0] ones_q;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the registered stage.
    logic [WIDTH-1:0] m_fq;
    int               m_ones;
    logic             m_par;
    logic             m_zero;
    logic             m_ov;

    xor_bitwise #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .f         (f),
        .f_q       (f_q),
        .out_valid (out_valid),
        .zero_q    (zero_q),
        .parity_q  (parity_q),
        .ones_q    (ones_q)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int count_ones(input logic [WIDTH-1:0] v);
        int n = 0;
        for (int i = 0; i < WIDTH; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_fq   = '0;
        m_ones = 0;
        m_par  = 1'b0;
        m_zero = 1'b0;
        m_ov   = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".f_q"},       32'(f_q),       32'(m_fq));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        check({tag, ".zero_q"},    32'(zero_q),    32'(m_zero));
        check({tag, ".parity_q"},  32'(parity_q),  32'(m_par));
        check({tag, ".ones_q"},    32'(ones_q),    32'(m_ones));
    endtask

    // Drive one cycle: inputs change at the falling edge, f is checked
    // before the rising edge, and the registered outputs just after it.
    task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb);
        @(negedge clk);
        in_valid = v;
        a        = va;
        b        = vb;
        #1;
        check({tag, ".f"}, 32'(f), 32'(va ^ vb));
        @(posedge clk);
        #1;
        if (v) begin
            m_fq   = va ^ vb;
            m_ones = count_ones(va ^ vb);
            m_par  = (m_ones % 2) == 1;
            m_zero = (va == vb);
        end
        m_ov = v;
        check_regs(tag);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = 16'habab;
        b        = 16'hffff;
        model_reset();
        #1;
        check("t1.f", 32'(f), 32'h5454);
        check_regs("reset");
        #10;
        a = 16'h0101;
        b = 16'h5555;
        #1;
        check("t2.f_comb", 32'(f), 32'h5454);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases, including the equal-operand and complement boundaries.
        step("t2",  1'b1, 16'h0101, 16'h5555);
        check("t2.ones6", 32'(ones_q), 32'd6);
        step("t3",  1'b1, 16'h1234, 16'h1234);
        check("t3.zero", 32'(zero_q), 32'd1);
        step("t4a", 1'b1, 16'h0000, 16'hffff);
        check("t4a.ones16", 32'(ones_q), 32'd16);
        step("t4b", 1'b1, 16'h0001, 16'h0000);
        check("t4b.parity", 32'(parity_q), 32'd1);
        step("idle", 1'b0, 16'hdead, 16'hbeef);

        // Three back-to-back valids, then idle: the last result must hold.
        step("t5.0", 1'b1, 16'h1111, 16'h2222);
        step("t5.1", 1'b1, 16'h00ff, 16'h0f0f);
        step("t5.2", 1'b1, 16'hc3c3, 16'h3c3c);
        step("t5.3", 1'b0, 16'h0000, 16'h0000);
        check("t5.hold", 32'(f_q), 32'hffff);

        // Asynchronous reset between clock edges while out_valid is high.
        step("t6.pre", 1'b1, 16'h8421, 16'h0f0f);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_regs("t6.rst");
        check("t6.f", 32'(f), 32'(a ^ b));
        @(posedge clk);
        #1;
        check_regs("t6.held");
        @(negedge clk);
        rst = 1'b0;

        // Random traffic with a random valid pattern.
        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            rb = (($urandom % 8) == 0) ? ra : WIDTH'($urandom);
            step("rand", 1'(($urandom % 4) != 0), ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
